// File: rtl/channel_reader_pkg.sv
// Shared definitions for the channel readout engine: FSM encoding and FIFO/bank timing constants.

package channel_reader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned FIFO_DEPTH   = 2;
  localparam int unsigned READ_LATENCY = 1;
  localparam int unsigned FIFO_CNT_W   = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/channel_reader_fifo.sv
// Two-entry synchronous skid FIFO with same-cycle push/pop and synchronous active-low clear.

module channel_reader_fifo
  import channel_reader_pkg::*;
#(
  parameter int unsigned Width = 49
) (
  input  logic                  clk_i,
  input  logic                  clr_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [Width-1:0]      wdata_i,
  output logic [Width-1:0]      rdata_o,
  output logic [FIFO_CNT_W-1:0] count_o
);

  localparam logic [FIFO_CNT_W-1:0] Full = FIFO_CNT_W'(FIFO_DEPTH);

  logic [Width-1:0]      mem_q [FIFO_DEPTH];
  logic [Width-1:0]      mem_d [FIFO_DEPTH];
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic                  push_en, pop_en;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    pop_en   = pop_i && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_en  = push_i && ((count_q != Full) || pop_en);
    if (push_en) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_en) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + FIFO_CNT_W'(push_en) - FIFO_CNT_W'(pop_en);
  end

  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/channel_reader.sv
// Reads N pixels from the three-channel bank and streams them out on valid/ready.
// Optional CHANNEL_READER_ABORT_EN adds an Abort input that cancels a readout in progress.

module channel_reader
  import channel_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   CHANNEL_READER_Clk,
  input  logic                   CHANNEL_READER_Reset,
`ifdef CHANNEL_READER_ABORT_EN
  input  logic                   CHANNEL_READER_Abort,
`endif
  input  logic                   CHANNEL_READER_Start,
  input  logic [COUNT_WIDTH-1:0] CHANNEL_READER_Pixel_Count,
  input  logic [DATA_WIDTH-1:0]  CHANNEL_READER_Mem1_Data,
  input  logic [DATA_WIDTH-1:0]  CHANNEL_READER_Mem2_Data,
  input  logic [DATA_WIDTH-1:0]  CHANNEL_READER_Mem3_Data,
  input  logic                   CHANNEL_READER_Out_Ready,
  output logic                   CHANNEL_READER_Re,
  output logic                   CHANNEL_READER_Out_Valid,
  output logic [DATA_WIDTH-1:0]  CHANNEL_READER_Out_Ch1,
  output logic [DATA_WIDTH-1:0]  CHANNEL_READER_Out_Ch2,
  output logic [DATA_WIDTH-1:0]  CHANNEL_READER_Out_Ch3,
  output logic                   CHANNEL_READER_Out_Last,
  output logic                   CHANNEL_READER_Busy,
  output logic                   CHANNEL_READER_Done
);

  localparam int unsigned EntryW = 3 * DATA_WIDTH + 1;
  localparam logic [COUNT_WIDTH-1:0] CntOne  = COUNT_WIDTH'(1);
  localparam logic [FIFO_CNT_W:0]    Credits = (FIFO_CNT_W + 1)'(FIFO_DEPTH);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] target_q, target_d;
  logic [COUNT_WIDTH-1:0] issued_q, issued_d;
  logic                   inflight_q, inflight_d;
  logic                   inflight_last_q, inflight_last_d;

  logic [FIFO_CNT_W-1:0]  fifo_count;
  logic [EntryW-1:0]      fifo_head;
  logic [EntryW-1:0]      fifo_wdata;
  logic [FIFO_CNT_W:0]    occupancy;
  logic                   fifo_clr_n;
  logic                   out_valid;
  logic                   push, pop;
  logic                   credit_ok;
  logic                   re;
  logic                   abort_take;

`ifdef CHANNEL_READER_ABORT_EN
  assign abort_take = CHANNEL_READER_Abort && ((state_q == StRead) || (state_q == StDrain));
`else
  assign abort_take = 1'b0;
`endif

  assign out_valid  = (fifo_count != '0);
  assign pop        = out_valid && CHANNEL_READER_Out_Ready;
  assign push       = inflight_q && !abort_take;
  assign fifo_clr_n = CHANNEL_READER_Reset && !abort_take;
  assign fifo_wdata = {inflight_last_q, CHANNEL_READER_Mem1_Data, CHANNEL_READER_Mem2_Data,
                       CHANNEL_READER_Mem3_Data};

  // Words already held or returning next cycle, less the one leaving now, must fit the FIFO.
  assign occupancy = {1'b0, fifo_count} + {{FIFO_CNT_W{1'b0}}, inflight_q}
                     - {{FIFO_CNT_W{1'b0}}, pop};
  assign credit_ok = (occupancy < Credits);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    issued_d = issued_q;
    re       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (CHANNEL_READER_Start) begin
          target_d = CHANNEL_READER_Pixel_Count;
          issued_d = '0;
          state_d  = (CHANNEL_READER_Pixel_Count == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        re = (issued_q < target_q) && credit_ok;
        if (re) begin
          issued_d = issued_q + CntOne;
        end
        if (issued_d == target_q) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if ((fifo_count == '0) && !inflight_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (abort_take) begin
      re       = 1'b0;
      issued_d = '0;
      state_d  = StDone;
    end
    inflight_d      = re;
    inflight_last_d = re && (issued_q == target_q - CntOne);
  end

  always_ff @(posedge CHANNEL_READER_Clk) begin
    if (!CHANNEL_READER_Reset) begin
      state_q         <= StIdle;
      target_q        <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      target_q        <= target_d;
      issued_q        <= issued_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  channel_reader_fifo #(
    .Width(EntryW)
  ) u_fifo (
    .clk_i  (CHANNEL_READER_Clk),
    .clr_ni (fifo_clr_n),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(fifo_wdata),
    .rdata_o(fifo_head),
    .count_o(fifo_count)
  );

  assign CHANNEL_READER_Re        = re;
  assign CHANNEL_READER_Out_Valid = out_valid;
  assign CHANNEL_READER_Out_Ch1   = fifo_head[3*DATA_WIDTH-1:2*DATA_WIDTH];
  assign CHANNEL_READER_Out_Ch2   = fifo_head[2*DATA_WIDTH-1:DATA_WIDTH];
  assign CHANNEL_READER_Out_Ch3   = fifo_head[DATA_WIDTH-1:0];
  assign CHANNEL_READER_Out_Last  = fifo_head[3*DATA_WIDTH] && out_valid;
  assign CHANNEL_READER_Busy      = (state_q != StIdle);
  assign CHANNEL_READER_Done      = (state_q == StDone);

endmodule

// File: tb/tb_channel_reader.sv
// Directed bench for channel_reader: bank model, pixel scoreboard, credit and stall monitors.

module tb_channel_reader;

  localparam int DW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n, start, ready, abort;
  logic [CW-1:0] pcount;
  logic [DW-1:0] mem1 = '0, mem2 = '0, mem3 = '0;
  logic          re, valid, last, busy, done;
  logic [DW-1:0] ch1, ch2, ch3;

  int total = 0;
  int bad   = 0;
  int pix_total = 0, last_total = 0, done_total = 0, re_total = 0, valid_total = 0;

  logic [63:0] sb_q[$];
  int          sb_idx = 0, sb_n = 0, outst = 0;
  int          bank_idx = 0;
  bit          stall_prev = 1'b0;
  bit          pop_s;
  logic [63:0] stall_val, obs_v, exp_v;

  always #5 clk = ~clk;

  channel_reader #(
    .DATA_WIDTH (DW),
    .COUNT_WIDTH(CW)
  ) dut (
    .CHANNEL_READER_Clk        (clk),
    .CHANNEL_READER_Reset      (rst_n),
`ifdef CHANNEL_READER_ABORT_EN
    .CHANNEL_READER_Abort      (abort),
`endif
    .CHANNEL_READER_Start      (start),
    .CHANNEL_READER_Pixel_Count(pcount),
    .CHANNEL_READER_Mem1_Data  (mem1),
    .CHANNEL_READER_Mem2_Data  (mem2),
    .CHANNEL_READER_Mem3_Data  (mem3),
    .CHANNEL_READER_Out_Ready  (ready),
    .CHANNEL_READER_Re         (re),
    .CHANNEL_READER_Out_Valid  (valid),
    .CHANNEL_READER_Out_Ch1    (ch1),
    .CHANNEL_READER_Out_Ch2    (ch2),
    .CHANNEL_READER_Out_Ch3    (ch3),
    .CHANNEL_READER_Out_Last   (last),
    .CHANNEL_READER_Busy       (busy),
    .CHANNEL_READER_Done       (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pixel(input int k, input bit l);
    logic [15:0] a, b, c;
    a = 16'(32'h0101 * k);
    b = 16'(32'h0202 * k);
    c = 16'(32'h0303 * k);
    return {15'b0, a, b, c, l};
  endfunction

  // Bank: words for the k-th read (k from 1) appear the cycle after Re.
  always @(posedge clk) begin
    if (!rst_n) begin
      bank_idx <= 0;
    end else if (start && !busy) begin
      bank_idx <= 0;
    end else if (re) begin
      mem1     <= 16'(32'h0101 * (bank_idx + 1));
      mem2     <= 16'(32'h0202 * (bank_idx + 1));
      mem3     <= 16'(32'h0303 * (bank_idx + 1));
      bank_idx <= bank_idx + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      outst      = 0;
      stall_prev = 1'b0;
    end else begin
      pop_s = valid && ready;
      obs_v = {15'b0, ch1, ch2, ch3, last};
      if (start && !busy) begin
        sb_idx = 0;
        sb_n   = int'(pcount);
      end
      if (stall_prev) begin
        chk("stall_valid", 64'(valid), 64'd1);
        chk("stall_hold", obs_v, stall_val);
      end
      if (re) begin
        chk("credit", 64'((outst - int'(pop_s)) < 2), 64'd1);
        sb_q.push_back(pixel(sb_idx + 1, (sb_idx + 1) == sb_n));
        sb_idx++;
        re_total++;
      end
      if (pop_s) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 64'(sb_q.size()), 64'd1);
        end else begin
          exp_v = sb_q.pop_front();
          chk("pixel", obs_v, exp_v);
        end
        pix_total++;
        if (last) last_total++;
      end
      if (valid) valid_total++;
      if (done) done_total++;
      outst      = outst + int'(re) - int'(pop_s);
      stall_prev = valid && !ready;
      stall_val  = obs_v;
      if (abort && busy && !done) begin
        sb_q.delete();
        outst      = 0;
        stall_prev = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start  = 1'b1;
    pcount = CW'(n);
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(input int bound, input bit toggle, output bit ok);
    int ph;
    ok = 1'b0;
    ph = 0;
    for (int i = 0; i < bound; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      ready = toggle ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
      ph++;
      tick();
    end
    if (!ok) ok = done;
    ready = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_re"}, 64'(re), 64'd0);
    chk({tag, "_valid"}, 64'(valid), 64'd0);
    chk({tag, "_last"}, 64'(last), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_ch"}, {16'b0, ch1, ch2, ch3}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int p0, l0, d0, r0, v0;
    rst_n  = 1'b0;
    start  = 1'b0;
    ready  = 1'b1;
    abort  = 1'b0;
    pcount = '0;
    repeat (2) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Stream N=5
    p0 = pix_total; l0 = last_total; d0 = done_total;
    do_start(5);
    chk("re_first", 64'(re), 64'd1);
    chk("busy_run", 64'(busy), 64'd1);
    tick();
    chk("valid_e1", 64'(valid), 64'd0);
    tick();
    chk("valid_e2", 64'(valid), 64'd1);
    chk("first_ch1", 64'(ch1), 64'h0101);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stream_valid", 64'(valid), 64'd1);
    end
    chk("last_5th", 64'(last), 64'd1);
    chk("ch3_5th", 64'(ch3), 64'h0f0f);
    wait_done(10, 1'b0, ok);
    chk("stream_done", 64'(ok), 64'd1);
    chk("stream_pix", 64'(pix_total - p0), 64'd5);
    chk("stream_last", 64'(last_total - l0), 64'd1);
    tick();
    chk("done_pulse", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("done_count", 64'(done_total - d0), 64'd1);

    // Backpressure N=6
    p0 = pix_total; l0 = last_total;
    do_start(6);
    wait_done(80, 1'b1, ok);
    chk("bp_done", 64'(ok), 64'd1);
    chk("bp_pix", 64'(pix_total - p0), 64'd6);
    chk("bp_last", 64'(last_total - l0), 64'd1);
    chk("bp_sb_empty", 64'(sb_q.size()), 64'd0);
    tick();

    // Zero count
    r0 = re_total; v0 = valid_total;
    do_start(0);
    wait_done(3, 1'b0, ok);
    chk("zero_done", 64'(ok), 64'd1);
    tick();
    chk("zero_re", 64'(re_total - r0), 64'd0);
    chk("zero_valid", 64'(valid_total - v0), 64'd0);
    chk("zero_idle", 64'(busy), 64'd0);

    // Start while busy
    p0 = pix_total; l0 = last_total;
    do_start(4);
    tick();
    start  = 1'b1;
    pcount = CW'(7);
    tick();
    start  = 1'b0;
    wait_done(40, 1'b0, ok);
    chk("busy_start_done", 64'(ok), 64'd1);
    chk("busy_start_pix", 64'(pix_total - p0), 64'd4);
    chk("busy_start_last", 64'(last_total - l0), 64'd1);
    tick();

    // Reset mid-readout
    p0 = pix_total;
    do_start(8);
    for (int i = 0; i < 40 && (pix_total - p0) < 3; i++) tick();
    chk("mid_reached3", 64'((pix_total - p0) >= 3), 64'd1);
    rst_n = 1'b0;
    repeat (2) tick();
    chk_all_zero("mid_reset");
    rst_n = 1'b1;
    tick();
    p0 = pix_total; l0 = last_total;
    do_start(4);
    wait_done(40, 1'b0, ok);
    chk("post_reset_done", 64'(ok), 64'd1);
    chk("post_reset_pix", 64'(pix_total - p0), 64'd4);
    chk("post_reset_last", 64'(last_total - l0), 64'd1);
    tick();

`ifdef CHANNEL_READER_ABORT_EN
    p0 = pix_total; l0 = last_total;
    do_start(10);
    for (int i = 0; i < 40 && (pix_total - p0) < 2; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_re", 64'(re), 64'd0);
    chk("abort_valid", 64'(valid), 64'd0);
    chk("abort_done", 64'(done), 64'd1);
    tick();
    chk("abort_idle", 64'(busy), 64'd0);
    chk("abort_no_last", 64'(last_total - l0), 64'd0);
    tick();
`endif

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
